dense_output_streamer: RTL and testbench

Reads back the activated results stored by the decoder dense layer, after that layer asserts `done`. Drives the layer's read port (`dense_output_address` / `dense_output_enable` / `dense_output_data`). Hides the BRAM read latency behind a pipelined issue stage and a small FIFO, and presents neurons in index order on a valid/ready stream. It also keeps a running signed argmax, which the classifier stage uses.

---
 rtl/dense_output_streamer_pkg.sv | 31 +++
 rtl/dense_output_streamer_if.sv | 14 +
 rtl/dense_stream_fifo.sv | 74 +++++++
 rtl/dense_output_streamer.sv | 137 +++++++++++++
 tb/tb_dense_output_streamer.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dense_output_streamer_pkg.sv
// Shared constants and types for the dense-layer readback stream.
// The dense layer and relu blocks use the same Q-format and neuron count.
package dense_output_streamer_pkg;

  localparam int unsigned NEURON         = 100;
  localparam int unsigned INTEGER_WIDTH  = 10;
  localparam int unsigned FRACTION_WIDTH = 10;
  localparam int unsigned DATA_W         = INTEGER_WIDTH + FRACTION_WIDTH;
  localparam int unsigned ADDR_W         = 7;
  localparam int unsigned READ_LATENCY   = 2;
  localparam int unsigned FIFO_DEPTH     = 4;

  // Most-negative signed Q value, used to seed the running argmax
  localparam logic [DATA_W-1:0] Q_MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] index;
    logic              last;
  } stream_beat_t;

  localparam int unsigned BEAT_W = $bits(stream_beat_t);

endpackage

// File: rtl/dense_output_streamer_if.sv
// Valid/ready neuron stream; the streamer is the master.
interface dense_output_streamer_if;
  import dense_output_streamer_pkg::*;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_index;
  logic              m_last;

  modport master (output m_valid, m_data, m_index, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_index, m_last, output m_ready);

endinterface

// File: rtl/dense_stream_fifo.sv
// Synchronous FIFO with a registered head; DEPTH must be a power of two.
module dense_stream_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             head_valid,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] count_q, count_nxt;
  logic             do_push, do_pop;

  assign empty   = ~head_valid;
  assign do_push = push & ~full;
  assign do_pop  = pop & head_valid;

  always_comb begin
    count_nxt = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  // Head register always mirrors the oldest entry so the output is flop-driven
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      full       <= 1'b0;
      head_valid <= 1'b0;
      head       <= '0;
    end else if (clear) begin
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      full       <= 1'b0;
      head_valid <= 1'b0;
      head       <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      count_q <= count_nxt;
      full    <= (count_nxt == CNT_W'(DEPTH));
      if (!head_valid || do_pop) begin
        if (do_pop && (count_q > CNT_W'(1))) begin
          head       <= mem_q[rd_q + PTR_W'(1)];
          head_valid <= 1'b1;
        end else if (do_push) begin
          head       <= din;
          head_valid <= 1'b1;
        end else begin
          head       <= '0;
          head_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/dense_output_streamer.sv
// Reads the dense layer's result BRAM in index order and streams it out,
// hiding read latency with credit-limited issue and tracking a signed argmax.
module dense_output_streamer
  import dense_output_streamer_pkg::*;
#(
  parameter int unsigned read_latency = READ_LATENCY,
  parameter int unsigned fifo_depth   = FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    layer_done,
  output logic [ADDR_W-1:0]       dense_output_address,
  output logic                    dense_output_enable,
  input  logic [DATA_W-1:0]       dense_output_data,
  dense_output_streamer_if.master m,
  output logic [ADDR_W-1:0]       argmax_index,
  output logic [DATA_W-1:0]       argmax_value,
  output logic                    done
);

  localparam int unsigned CRED_W  = $clog2(fifo_depth + 1);
  localparam int unsigned ISSUE_W = ADDR_W + 1;
  localparam int unsigned TAG_OUT = read_latency - 1;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] idx;
  } tag_t;

  state_t             state_q, state_nxt;
  logic [ISSUE_W-1:0] issue_idx_q;
  logic [CRED_W-1:0]  credits_q;
  tag_t               tag_q [read_latency];
  logic               issue, flush, pop;
  logic               fifo_push, fifo_full, fifo_empty, head_valid;
  logic [BEAT_W-1:0]  fifo_head;
  stream_beat_t       push_beat, head_beat;

  assign pop       = m.m_ready & ~fifo_empty;
  assign head_beat = stream_beat_t'(fifo_head);
  assign m.m_valid = head_valid;
  assign m.m_data  = head_beat.data;
  assign m.m_index = head_beat.index;
  assign m.m_last  = head_beat.last;

  // Next state plus the issue decision for the following cycle
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (layer_done) state_nxt = ST_RUN;
      ST_RUN:   if (!layer_done) state_nxt = ST_IDLE;
                else if (issue_idx_q == ISSUE_W'(NEURON)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!layer_done) state_nxt = ST_IDLE;
                else if (pop && head_beat.last) state_nxt = ST_DONE;
      ST_DONE:  if (!layer_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    flush = (state_nxt == ST_IDLE);
    // A same-cycle pop frees a slot, keeping one issue per cycle at full rate
    issue = (state_nxt == ST_RUN) && (issue_idx_q < ISSUE_W'(NEURON)) &&
            ((credits_q != '0) || pop);
  end

  always_comb begin
    push_beat.data  = dense_output_data;
    push_beat.index = tag_q[TAG_OUT].idx;
    push_beat.last  = (tag_q[TAG_OUT].idx == ADDR_W'(NEURON - 1));
    fifo_push       = tag_q[TAG_OUT].vld & ~flush;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // Issue counter, credits, read port and tag pipe aligned to BRAM latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_idx_q          <= '0;
      credits_q            <= CRED_W'(fifo_depth);
      dense_output_enable  <= 1'b0;
      dense_output_address <= '0;
      for (int unsigned i = 0; i < read_latency; i++) tag_q[i] <= '0;
    end else if (flush) begin
      issue_idx_q         <= '0;
      credits_q           <= CRED_W'(fifo_depth);
      dense_output_enable <= 1'b0;
      for (int unsigned i = 0; i < read_latency; i++) tag_q[i] <= '0;
    end else begin
      dense_output_enable <= issue;
      if (issue) begin
        dense_output_address <= issue_idx_q[ADDR_W-1:0];
        issue_idx_q          <= issue_idx_q + ISSUE_W'(1);
      end
      credits_q <= credits_q - CRED_W'(issue) + CRED_W'(pop);
      tag_q[0].vld <= dense_output_enable;
      tag_q[0].idx <= dense_output_address;
      for (int unsigned i = 1; i < read_latency; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Strict greater-than keeps the lower index on ties
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      argmax_index <= '0;
      argmax_value <= '0;
      done         <= 1'b0;
    end else begin
      done <= (state_nxt == ST_DONE);
      if ((state_q == ST_IDLE) && (state_nxt == ST_RUN)) begin
        argmax_index <= '0;
        argmax_value <= Q_MOST_NEG;
      end else if (fifo_push && !fifo_full &&
                   ($signed(dense_output_data) > $signed(argmax_value))) begin
        argmax_index <= tag_q[TAG_OUT].idx;
        argmax_value <= dense_output_data;
      end
    end
  end

  dense_stream_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush),
    .push       (fifo_push),
    .din        (push_beat),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_valid (head_valid),
    .head       (fifo_head)
  );

endmodule

// File: tb/tb_dense_output_streamer.sv
// Directed bench for dense_output_streamer with a 2-cycle BRAM read model.
module tb_dense_output_streamer;
  import dense_output_streamer_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              layer_done;
  logic [ADDR_W-1:0] dense_output_address;
  logic              dense_output_enable;
  logic [DATA_W-1:0] dense_output_data;
  logic [ADDR_W-1:0] argmax_index;
  logic [DATA_W-1:0] argmax_value;
  logic              done;

  dense_output_streamer_if s_if ();

  dense_output_streamer dut (
    .clk                  (clk),
    .reset                (reset),
    .layer_done           (layer_done),
    .dense_output_address (dense_output_address),
    .dense_output_enable  (dense_output_enable),
    .dense_output_data    (dense_output_data),
    .m                    (s_if),
    .argmax_index         (argmax_index),
    .argmax_value         (argmax_value),
    .done                 (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: two registered stages, matching READ_LATENCY = 2
  logic [DATA_W-1:0] mem [128];
  logic [DATA_W-1:0] rd1, rd2;
  always @(posedge clk) begin
    if (dense_output_enable) rd1 <= mem[dense_output_address];
    rd2 <= rd1;
  end
  assign dense_output_data = rd2;

  int errors = 0;
  int checks = 0;

  int                got_idx [$];
  logic [DATA_W-1:0] got_data [$];
  bit                got_last [$];
  int raise_cyc, first_issue_cyc, last_hs_cyc, issues, max_out, hold_issues, hold_valid0;
  bit timeout;

  task automatic load_ramp();
    for (int i = 0; i < 128; i++) mem[i] = DATA_W'(i * 1024);
  endtask

  // Raises layer_done (call at a negedge) and records beats until the m_last handshake
  task automatic collect(input int ready_pct, input int hold_off);
    int outst = 0;
    got_idx.delete(); got_data.delete(); got_last.delete();
    timeout = 1'b1; first_issue_cyc = -1; issues = 0; max_out = 0;
    hold_issues = 0; hold_valid0 = 0; last_hs_cyc = -1;
    layer_done = 1'b1;
    raise_cyc = cyc;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      s_if.m_ready = (c >= hold_off) && (int'($urandom_range(99)) < ready_pct);
      if (dense_output_enable) begin
        issues++; outst++;
        if (c < hold_off) hold_issues++;
        if (first_issue_cyc < 0) first_issue_cyc = cyc;
      end
      if (outst > max_out) max_out = outst;
      if (c < hold_off && s_if.m_valid && s_if.m_index == 0) hold_valid0++;
      if (s_if.m_valid && s_if.m_ready) begin
        got_idx.push_back(int'(s_if.m_index));
        got_data.push_back(s_if.m_data);
        got_last.push_back(s_if.m_last);
        outst--;
        if (s_if.m_last) begin
          last_hs_cyc = cyc;
          timeout = 1'b0;
          break;
        end
      end
    end
  endtask

  task automatic end_run();
    layer_done = 1'b0;
    s_if.m_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; layer_done = 1'b0; s_if.m_ready = 1'b0;
    load_ramp();
    repeat (3) @(negedge clk);
    checks++;
    if ({s_if.m_valid, s_if.m_last, done, dense_output_enable} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000",
                         {s_if.m_valid, s_if.m_last, done, dense_output_enable});
    end
    checks++;
    if (argmax_index !== '0 || argmax_value !== '0 || dense_output_address !== '0) begin
      errors++; $display("FAIL reset_values: got idx=%0d val=%h addr=%0d expected 0",
                         argmax_index, argmax_value, dense_output_address);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_if.m_valid, done, dense_output_enable} !== 3'b0) begin
      errors++; $display("FAIL idle_after_reset: got %b expected 000",
                         {s_if.m_valid, done, dense_output_enable});
    end
  endtask

  task automatic test_ramp();
    collect(100, 0);
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL ramp_timeout: got timeout=1 expected 0"); end
    checks++;
    if (first_issue_cyc !== raise_cyc + 1) begin
      errors++; $display("FAIL ramp_first_issue: got cycle %0d expected %0d", first_issue_cyc, raise_cyc + 1);
    end
    checks++;
    if (got_idx.size() !== NEURON) begin
      errors++; $display("FAIL ramp_count: got %0d expected %0d", got_idx.size(), NEURON);
    end
    for (int i = 0; i < got_idx.size(); i++) begin
      checks++;
      if (got_idx[i] !== i || got_data[i] !== DATA_W'(i * 1024) || got_last[i] !== (i == NEURON - 1)) begin
        errors++; $display("FAIL ramp_beat%0d: got idx=%0d data=%h last=%0d expected idx=%0d data=%h last=%0d",
                           i, got_idx[i], got_data[i], got_last[i], i, DATA_W'(i * 1024), (i == NEURON - 1));
      end
    end
    // Last item issued at first+99, visible two cycles later, valid one after that
    checks++;
    if (last_hs_cyc - first_issue_cyc !== NEURON + READ_LATENCY) begin
      errors++; $display("FAIL ramp_latency: got %0d expected %0d",
                         last_hs_cyc - first_issue_cyc, NEURON + READ_LATENCY);
    end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL ramp_done_early: got %0d expected 0", done); end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL ramp_done: got %0d expected 1", done); end
    checks++;
    if (argmax_index !== 7'd99 || argmax_value !== 20'h18C00) begin
      errors++; $display("FAIL ramp_argmax: got idx=%0d val=%h expected idx=99 val=18c00",
                         argmax_index, argmax_value);
    end
    layer_done = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_clear: got %0d expected 0", done); end
    end_run();
  endtask

  task automatic test_random_ready();
    collect(50, 0);
    checks++;
    if (timeout !== 1'b0 || got_idx.size() !== NEURON || issues !== NEURON) begin
      errors++; $display("FAIL rand_count: got timeout=%0d beats=%0d issues=%0d expected 0/100/100",
                         timeout, got_idx.size(), issues);
    end
    for (int i = 0; i < got_idx.size(); i++) begin
      checks++;
      if (got_idx[i] !== i || got_data[i] !== DATA_W'(i * 1024)) begin
        errors++; $display("FAIL rand_beat%0d: got idx=%0d data=%h expected idx=%0d data=%h",
                           i, got_idx[i], got_data[i], i, DATA_W'(i * 1024));
      end
    end
    checks++;
    if (max_out > FIFO_DEPTH) begin
      errors++; $display("FAIL rand_outstanding: got %0d expected <= %0d", max_out, FIFO_DEPTH);
    end
    end_run();
  endtask

  task automatic test_argmax_tie();
    for (int i = 0; i < 128; i++) mem[i] = 20'hFFC00;
    mem[37] = 20'h00800;
    mem[62] = 20'h00800;
    collect(100, 0);
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL tie_done: got timeout=%0d done=%0d expected 0/1", timeout, done);
    end
    checks++;
    if (argmax_index !== 7'd37) begin
      errors++; $display("FAIL tie_index: got %0d expected 37", argmax_index);
    end
    checks++;
    if (argmax_value !== 20'h00800) begin
      errors++; $display("FAIL tie_value: got %h expected 00800", argmax_value);
    end
    end_run();
    load_ramp();
  endtask

  task automatic test_backpressure();
    collect(100, 20);
    checks++;
    if (hold_issues !== 4) begin
      errors++; $display("FAIL bp_issues: got %0d expected 4", hold_issues);
    end
    // Issued at hold cycle 0, head valid from hold cycle 3 through 19
    checks++;
    if (hold_valid0 !== 17) begin
      errors++; $display("FAIL bp_hold_head: got %0d cycles expected 17", hold_valid0);
    end
    checks++;
    if (timeout !== 1'b0 || got_idx.size() !== NEURON) begin
      errors++; $display("FAIL bp_complete: got timeout=%0d beats=%0d expected 0/100", timeout, got_idx.size());
    end
    for (int i = 0; i < got_idx.size(); i++) begin
      checks++;
      if (got_idx[i] !== i) begin
        errors++; $display("FAIL bp_beat%0d: got idx=%0d expected %0d", i, got_idx[i], i);
      end
    end
    end_run();
  endtask

  task automatic test_abort();
    bit hit = 1'b0;
    int en_seen = 0;
    layer_done = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      s_if.m_ready = 1'b1;
      if (s_if.m_valid && s_if.m_index == 7'd50) begin
        layer_done = 1'b0;
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL abort_reach50: got 0 expected 1"); end
    @(negedge clk);
    checks++;
    if (s_if.m_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_drop: got valid=%0d done=%0d expected 0/0", s_if.m_valid, done);
    end
    checks++;
    if (dut.state_q !== ST_IDLE) begin
      errors++; $display("FAIL abort_state: got %0d expected %0d", dut.state_q, ST_IDLE);
    end
    repeat (4) begin
      @(negedge clk);
      if (dense_output_enable || s_if.m_valid) en_seen++;
    end
    checks++;
    if (en_seen !== 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", en_seen); end
    collect(100, 0);
    checks++;
    if (timeout !== 1'b0 || got_idx.size() !== NEURON) begin
      errors++; $display("FAIL restart_count: got timeout=%0d beats=%0d expected 0/100", timeout, got_idx.size());
    end
    checks++;
    if (got_idx.size() == 0 || got_idx[0] !== 0) begin
      errors++; $display("FAIL restart_first: got size=%0d expected first index 0", got_idx.size());
    end
    end_run();
  endtask

  task automatic test_reset_midstream();
    bit saw_en = 1'b0;
    bit in_drain = 1'b0;
    layer_done = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      s_if.m_ready = 1'b1;
      if (dense_output_enable) saw_en = 1'b1;
      else if (saw_en) begin in_drain = 1'b1; break; end
    end
    checks++;
    if (in_drain !== 1'b1 || s_if.m_valid !== 1'b1) begin
      errors++; $display("FAIL rst_drain_reach: got drain=%0d valid=%0d expected 1/1", in_drain, s_if.m_valid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({s_if.m_valid, s_if.m_last, done, dense_output_enable} !== 4'b0 ||
        s_if.m_index !== '0 || s_if.m_data !== '0) begin
      errors++; $display("FAIL rst_async_stream: got valid=%0d last=%0d done=%0d en=%0d idx=%0d data=%h expected 0",
                         s_if.m_valid, s_if.m_last, done, dense_output_enable, s_if.m_index, s_if.m_data);
    end
    checks++;
    if (argmax_index !== '0 || argmax_value !== '0 || dense_output_address !== '0) begin
      errors++; $display("FAIL rst_async_values: got idx=%0d val=%h addr=%0d expected 0",
                         argmax_index, argmax_value, dense_output_address);
    end
    layer_done = 1'b0;
    s_if.m_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    collect(100, 0);
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0 || got_idx.size() !== NEURON || done !== 1'b1) begin
      errors++; $display("FAIL rst_rerun: got timeout=%0d beats=%0d done=%0d expected 0/100/1",
                         timeout, got_idx.size(), done);
    end
    checks++;
    if (argmax_index !== 7'd99) begin
      errors++; $display("FAIL rst_rerun_argmax: got %0d expected 99", argmax_index);
    end
    end_run();
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_random_ready();
    test_argmax_tie();
    test_backpressure();
    test_abort();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
